// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC, next-PC select, req/ready fetch, one-entry hold buffer, IF/ID register.
// Optional fetch address-error detection is enabled by defining IF_ADEL_EN.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
`ifdef IF_ADEL_EN
  ,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IM_SIZE  = 32'h0000_4000
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic [31:0] Branch,
  input  logic [31:0] jump,
  input  logic [31:0] ra,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ready,
  input  logic [31:0] im_rdata,
  output logic [31:0] PC_IF,
  output logic [31:0] Instr_ID,
  output logic [31:0] PC4_ID,
  output logic        if_busy
`ifdef IF_ADEL_EN
  ,
  output logic        exc_adel_ID
`endif
);

  localparam logic [0:0] FETCH = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  logic [0:0]  state;
  logic [31:0] pc4_if;
  logic [31:0] npc;
  logic [31:0] fetch_data;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc4;
  logic        illegal;
  logic        fetch_done;
  logic        advance_fetch;
  logic        advance_hold;
  logic        capture;

`ifdef IF_ADEL_EN
  assign illegal = (PC_IF[1:0] != 2'b00) || (PC_IF < IM_BASE) || ((PC_IF - IM_BASE) >= IM_SIZE);
`else
  assign illegal = 1'b0;
`endif

  // An illegal PC never reaches memory; it completes on its own with a zero word.
  assign fetch_done = illegal || im_ready;
  assign fetch_data = illegal ? 32'h0 : im_rdata;
  assign pc4_if     = PC_IF + 32'd4;

  // Gating with reset drops the request combinationally the moment reset asserts.
  assign im_req  = reset && (state == FETCH) && !illegal;
  assign im_addr = PC_IF;
  assign if_busy = reset && (state == FETCH) && !fetch_done;

  assign advance_fetch = (state == FETCH) && fetch_done && !stall;
  assign capture       = (state == FETCH) && fetch_done && stall;
  assign advance_hold  = (state == HOLD) && !stall;

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    npc = pc4_if;
    case (npc_sel)
      2'b01:   npc = Branch;
      2'b10:   npc = jump;
      2'b11:   npc = ra;
      default: npc = pc4_if;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PC_IF     <= RESET_PC;
      Instr_ID  <= 32'h0;
      PC4_ID    <= 32'h0;
      state     <= FETCH;
      buf_instr <= 32'h0;
      buf_pc4   <= 32'h0;
    end else begin
      if (advance_fetch) begin
        Instr_ID <= fetch_data;
        PC4_ID   <= pc4_if;
        PC_IF    <= npc;
      end else if (capture) begin
        buf_instr <= fetch_data;
        buf_pc4   <= pc4_if;
        state     <= HOLD;
      end else if (advance_hold) begin
        Instr_ID <= buf_instr;
        PC4_ID   <= buf_pc4;
        PC_IF    <= npc;
        state    <= FETCH;
      end
    end
  end

`ifdef IF_ADEL_EN
  logic buf_exc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exc_adel_ID <= 1'b0;
      buf_exc     <= 1'b0;
    end else begin
      if (advance_fetch) begin
        exc_adel_ID <= illegal;
      end else if (capture) begin
        buf_exc <= illegal;
      end else if (advance_hold) begin
        exc_adel_ID <= buf_exc;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboarded bench for if_fetch_stage: expected fetch addresses are queued by the stimulus and
// popped by a monitor on every completed request; IF/ID contents are checked directly.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  npc_sel;
  logic [31:0] Branch;
  logic [31:0] jump;
  logic [31:0] ra;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ready;
  logic [31:0] im_rdata;
  logic [31:0] PC_IF;
  logic [31:0] Instr_ID;
  logic [31:0] PC4_ID;
  logic        if_busy;
`ifdef IF_ADEL_EN
  logic        exc_adel_ID;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] expq[$];

  always #5 clk = ~clk;

  // Instruction memory model: the word at an address is C0DE in the top half, address below.
  assign im_rdata = {16'hC0DE, im_addr[15:0]};

  if_fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .npc_sel(npc_sel),
    .Branch(Branch), .jump(jump), .ra(ra),
    .im_req(im_req), .im_addr(im_addr), .im_ready(im_ready), .im_rdata(im_rdata),
    .PC_IF(PC_IF), .Instr_ID(Instr_ID), .PC4_ID(PC4_ID), .if_busy(if_busy)
`ifdef IF_ADEL_EN
    , .exc_adel_ID(exc_adel_ID)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic rdy, input logic stl, input logic [1:0] sel);
    im_ready = rdy;
    stall    = stl;
    npc_sel  = sel;
  endtask

  // Monitor: every completed request must match the next queued address.
  always @(negedge clk) begin
    if (im_req === 1'b1 && im_ready === 1'b1) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req: got addr %h expected no request at %0t", im_addr, $time);
      end else begin
        check("req_addr", im_addr, expq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [1:0]  seq_sel [6] = '{2'd1, 2'd0, 2'd3, 2'd0, 2'd2, 2'd0};
  logic [31:0] seq_next[6] = '{32'h3100, 32'h3104, 32'h3200, 32'h3204, 32'h3300, 32'h3304};

  initial begin
    logic [31:0] cur_pc;
    reset = 1'b0;
    set_in(1'b0, 1'b0, 2'd0);
    Branch = 32'h0; jump = 32'h0; ra = 32'h0;
    #12;
    check("rst_req", im_req, 32'd0);
    check("rst_pc", PC_IF, 32'h3000);
    check("rst_instr", Instr_ID, 32'h0);
    check("rst_pc4", PC4_ID, 32'h0);
    check("rst_busy", if_busy, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Back-to-back fetch with ready tied high.
    set_in(1'b1, 1'b0, 2'd0);
    expq.push_back(32'h3000);
    @(negedge clk);
    check("t1_req", im_req, 32'd1);
    check("t1_busy", if_busy, 32'd0);
    tick();
    check("t1_instr0", Instr_ID, 32'hC0DE_3000);
    check("t1_pc4_0", PC4_ID, 32'h3004);
    check("t1_pc0", PC_IF, 32'h3004);
`ifdef IF_ADEL_EN
    check("t1_exc", exc_adel_ID, 32'd0);
`endif
    expq.push_back(32'h3004);
    tick();
    check("t1_instr1", Instr_ID, 32'hC0DE_3004);
    expq.push_back(32'h3008);
    tick();
    check("t1_instr2", Instr_ID, 32'hC0DE_3008);
    check("t1_pc2", PC_IF, 32'h300C);

    // Memory not ready for three cycles (stall toggled in the middle one).
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, (i == 1), 2'd0);
      @(negedge clk);
      check("t2_busy", if_busy, 32'd1);
      check("t2_addr", im_addr, 32'h300C);
      check("t2_req", im_req, 32'd1);
      tick();
      check("t2_instr_held", Instr_ID, 32'hC0DE_3008);
      check("t2_pc_held", PC_IF, 32'h300C);
    end
    set_in(1'b1, 1'b0, 2'd0);
    expq.push_back(32'h300C);
    @(negedge clk);
    check("t2_busy_end", if_busy, 32'd0);
    tick();
    check("t2_instr", Instr_ID, 32'hC0DE_300C);
    check("t2_pc", PC_IF, 32'h3010);

    // Word completes under stall: captured into the hold buffer, not refetched.
    set_in(1'b1, 1'b1, 2'd0);
    expq.push_back(32'h3010);
    tick();
    check("t3_instr_held", Instr_ID, 32'hC0DE_300C);
    check("t3_pc_held", PC_IF, 32'h3010);
    set_in(1'b1, 1'b1, 2'd0);
    @(negedge clk);
    check("t3_hold_req", im_req, 32'd0);
    check("t3_hold_busy", if_busy, 32'd0);
    tick();
    check("t3_instr_held2", Instr_ID, 32'hC0DE_300C);
    set_in(1'b1, 1'b0, 2'd0);
    @(negedge clk);
    check("t3_release_req", im_req, 32'd0);
    tick();
    check("t3_instr", Instr_ID, 32'hC0DE_3010);
    check("t3_pc4", PC4_ID, 32'h3014);
    check("t3_pc", PC_IF, 32'h3014);

    // Branch, ra and jump redirects; the delay-slot word always enters ID.
    Branch = 32'h3100; ra = 32'h3200; jump = 32'h3300;
    cur_pc = 32'h3014;
    for (int i = 0; i < 6; i++) begin
      set_in(1'b1, 1'b0, seq_sel[i]);
      expq.push_back(cur_pc);
      tick();
      check("t4_instr", Instr_ID, {16'hC0DE, cur_pc[15:0]});
      check("t4_pc4", PC4_ID, cur_pc + 32'd4);
      check("t4_pc", PC_IF, seq_next[i]);
      cur_pc = seq_next[i];
    end

`ifndef IF_ADEL_EN
    // PC+4 wraps at the top of the address space.
    ra = 32'hFFFF_FFFC;
    set_in(1'b1, 1'b0, 2'd3);
    expq.push_back(32'h3304);
    tick();
    check("wrap_pc_top", PC_IF, 32'hFFFF_FFFC);
    set_in(1'b1, 1'b0, 2'd0);
    expq.push_back(32'hFFFF_FFFC);
    tick();
    check("wrap_pc4", PC4_ID, 32'h0);
    check("wrap_pc", PC_IF, 32'h0);
    check("wrap_instr", Instr_ID, 32'hC0DE_FFFC);
`endif

    // Reset during a pending fetch; a late ready during reset is ignored.
    set_in(1'b0, 1'b0, 2'd0);
    @(negedge clk);
    check("t5_busy_before", if_busy, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("t5_req", im_req, 32'd0);
    check("t5_pc", PC_IF, 32'h3000);
    check("t5_instr", Instr_ID, 32'h0);
    check("t5_pc4", PC4_ID, 32'h0);
    im_ready = 1'b1;
    tick();
    check("t5_late_ready_pc", PC_IF, 32'h3000);
    check("t5_late_ready_instr", Instr_ID, 32'h0);
    reset = 1'b1;
    set_in(1'b1, 1'b0, 2'd0);
    expq.push_back(32'h3000);
    @(negedge clk);
    check("t5_req_after", im_req, 32'd1);
    tick();
    check("t5_instr_after", Instr_ID, 32'hC0DE_3000);
    check("t5_pc4_after", PC4_ID, 32'h3004);

`ifdef IF_ADEL_EN
    // Misaligned ra, then an out-of-window jump target: both raise exc_adel_ID with a nop.
    ra = 32'h3002;
    set_in(1'b1, 1'b0, 2'd3);
    expq.push_back(32'h3004);
    tick();
    check("t6_pc_mis", PC_IF, 32'h3002);
    jump = 32'h7000;
    set_in(1'b1, 1'b0, 2'd2);
    @(negedge clk);
    check("t6_req_mis", im_req, 32'd0);
    check("t6_busy_mis", if_busy, 32'd0);
    tick();
    check("t6_instr_mis", Instr_ID, 32'h0);
    check("t6_exc_mis", exc_adel_ID, 32'd1);
    check("t6_pc4_mis", PC4_ID, 32'h3006);
    check("t6_pc_out", PC_IF, 32'h7000);
    jump = 32'h3008;
    set_in(1'b1, 1'b0, 2'd2);
    @(negedge clk);
    check("t6_req_out", im_req, 32'd0);
    tick();
    check("t6_instr_out", Instr_ID, 32'h0);
    check("t6_exc_out", exc_adel_ID, 32'd1);
    check("t6_pc4_out", PC4_ID, 32'h7004);
    set_in(1'b1, 1'b0, 2'd0);
    expq.push_back(32'h3008);
    tick();
    check("t6_instr_legal", Instr_ID, 32'hC0DE_3008);
    check("t6_exc_legal", exc_adel_ID, 32'd0);
`endif

    set_in(1'b0, 1'b0, 2'd0);
    tick();
    check("queue_drained", expq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
